ptch_integrator: RTL

//  Produces the fused pitch and pitch-rate samples consumed by the balance PID (ptch, ptch_rt, vld).

---
 rtl/ptch_integrator_if.sv | 21 ++
 rtl/ptch_integrator.sv | 111 +++++++++++
 2 files changed

// File: rtl/ptch_integrator_if.sv
// ptch_integrator_if
//   Bundles the raw inertial sample strobe and the fused pitch outputs.
//   master: sample producer / PID consumer side (drives raw_vld, ptch_rt_raw, AZ)
//   slave : ptch_integrator side (drives ptch, ptch_rt, vld)
//   raw_vld      1   one-cycle strobe, ptch_rt_raw/AZ valid
//   ptch_rt_raw  16  signed raw gyro pitch rate
//   AZ           16  signed raw accelerometer Z
//   ptch         16  signed fused pitch
//   ptch_rt      16  signed offset-corrected pitch rate
//   vld          1   one-cycle strobe, ptch/ptch_rt updated
interface ptch_integrator_if;
    logic        raw_vld;
    logic [15:0] ptch_rt_raw;
    logic [15:0] AZ;
    logic [15:0] ptch;
    logic [15:0] ptch_rt;
    logic        vld;

    modport master (output raw_vld, ptch_rt_raw, AZ, input ptch, ptch_rt, vld);
    modport slave  (input raw_vld, ptch_rt_raw, AZ, output ptch, ptch_rt, vld);
endinterface

// File: rtl/ptch_integrator.sv
// ptch_integrator
//   Calibrates out gyro offset at start-up, then integrates offset-corrected
//   pitch rate into a 27-bit pitch accumulator, nudged toward the
//   accelerometer-derived pitch by a fixed step per sample.
//   clk  : system clock, posedge
//   rst  : synchronous active-high reset
//   clr  : synchronous recalibrate (same effect as rst)
//   bus  : ptch_integrator_if.slave (raw samples in, fused samples out)
module ptch_integrator #(
    parameter int          CAL_LOG2 = 4,
    parameter int          FUSION   = 1024,
    parameter logic [15:0] AZ_OFST  = 16'h00A0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    ptch_integrator_if.slave  bus
);
    localparam logic [0:0] ST_CAL = 1'b0;
    localparam logic [0:0] ST_RUN = 1'b1;
    localparam logic signed [26:0] FUS = 27'(FUSION);

    logic [0:0]                    state;
    logic signed [15+CAL_LOG2:0]   cal_sum;
    logic [CAL_LOG2-1:0]           cal_cnt;
    logic signed [15:0]            ofst;
    logic signed [26:0]            ptch_int;
    logic signed [15:0]            ptch_rt_q;
    logic                          vld_q;
    logic signed [15:0]            rt_s1;
    logic signed [15:0]            acc_s1;
    logic                          v1;

    // Calibration accumulator input (sign-extended sample)
    logic signed [15+CAL_LOG2:0]   cal_next;
    assign cal_next = cal_sum + {{CAL_LOG2{bus.ptch_rt_raw[15]}}, bus.ptch_rt_raw};

    // Offset-corrected rate, 17-bit difference clamped to 16 bits
    logic signed [16:0] rt_diff;
    logic signed [15:0] rt_sat;
    assign rt_diff = {bus.ptch_rt_raw[15], bus.ptch_rt_raw} - {ofst[15], ofst};
    always_comb begin
        rt_sat = rt_diff[15:0];
        if (rt_diff[16] != rt_diff[15])
            rt_sat = rt_diff[16] ? 16'sh8000 : 16'sh7FFF;
    end

    // Accelerometer pitch estimate: (AZ - AZ_OFST) * 327, keep bits [25:13]
    logic signed [16:0] az_diff;
    logic signed [25:0] az_ext;
    logic signed [25:0] prod;
    logic signed [15:0] acc_next;
    assign az_diff  = {bus.AZ[15], bus.AZ} - {AZ_OFST[15], AZ_OFST};
    assign az_ext   = {{9{az_diff[16]}}, az_diff};
    assign prod     = az_ext * 26'sd327;
    assign acc_next = 16'(prod >>> 13);

    // Fusion step chosen against the pitch currently presented
    logic signed [15:0] ptch_cur;
    logic signed [26:0] fus;
    assign ptch_cur = ptch_int[26:11];
    always_comb begin
        fus = '0;
        if (acc_s1 > ptch_cur)      fus = FUS;
        else if (acc_s1 < ptch_cur) fus = -FUS;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state     <= ST_CAL;
            cal_sum   <= '0;
            cal_cnt   <= '0;
            ofst      <= '0;
            ptch_int  <= '0;
            ptch_rt_q <= '0;
            vld_q     <= 1'b0;
            rt_s1     <= '0;
            acc_s1    <= '0;
            v1        <= 1'b0;
        end else begin
            v1    <= 1'b0;
            vld_q <= v1;
            if (v1) begin
                ptch_rt_q <= rt_s1;
                // Gyro sign convention: positive rate lowers pitch
                ptch_int  <= ptch_int - {{11{rt_s1[15]}}, rt_s1} + fus;
            end
            case (state)
                ST_CAL: if (bus.raw_vld) begin
                    cal_sum <= cal_next;
                    cal_cnt <= cal_cnt + 1'b1;
                    // Completing sample only loads the offset; it produces no output
                    if (&cal_cnt) begin
                        ofst  <= 16'(cal_next >>> CAL_LOG2);
                        state <= ST_RUN;
                    end
                end
                ST_RUN: if (bus.raw_vld) begin
                    rt_s1  <= rt_sat;
                    acc_s1 <= acc_next;
                    v1     <= 1'b1;
                end
                default: state <= ST_CAL;
            endcase
        end
    end

    assign bus.ptch    = ptch_int[26:11];
    assign bus.ptch_rt = ptch_rt_q;
    assign bus.vld     = vld_q;
endmodule
